best_move_selector: RTL

- Consumer end of the move-evaluator output stream: accepts (move, eval, valid) results and keeps the maximum-eval legal move for the current candidate set.
- Counts candidates issued into the evaluator against results returned, so pipeline latency is absorbed without a fixed-depth assumption.
- Raises a one-cycle result strobe once the generator has finished and all outstanding evaluations have drained.
- Sits between the evaluator and the search controller.

---
 rtl/best_move_selector_pkg.sv | 16 +
 rtl/best_move_selector_inflight_counter.sv | 41 ++++
 rtl/best_move_selector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/best_move_selector_pkg.sv
// Types shared by the move evaluator, the best-move selector and the search controller.
package best_move_selector_pkg;

  typedef logic        [15:0] move_t;
  typedef logic signed [15:0] eval_t;

  localparam eval_t EVAL_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_COLLECT,
    SEL_DRAIN,
    SEL_DONE
  } sel_state_t;

endpackage

// File: rtl/best_move_selector_inflight_counter.sv
// Saturating up/down counter of evaluations in flight; flags underflow/overflow attempts.
module inflight_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_next_count,
  output logic         o_err
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_err;

  // Simultaneous inc and dec cancel, so neither boundary check applies.
  always_comb begin
    w_next = r_count;
    w_err  = 1'b0;
    if (i_clr) begin
      w_next = '0;
    end else if (i_inc && !i_dec) begin
      if (r_count == '1) w_err  = 1'b1;
      else               w_next = r_count + W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count == '0) w_err  = 1'b1;
      else               w_next = r_count - W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_count <= '0;
    else          r_count <= w_next;
  end

  assign o_next_count = w_next;
  assign o_err        = w_err;

endmodule

// File: rtl/best_move_selector.sv
// Collects evaluator results for one candidate set and reports the highest-scoring legal move.
module best_move_selector
  import best_move_selector_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             issue_in,
  input  logic             gen_done_in,
  input  logic             ret_in,
  input  move_t            move_in,
  input  eval_t            eval_in,
  input  logic             valid_in,
  output move_t            best_move_out,
  output eval_t            best_eval_out,
  output logic [CNT_W-1:0] num_legal_out,
  output logic             no_legal_out,
  output logic             result_valid_out,
  output logic             busy_out,
  output logic             error_out
);

  sel_state_t       r_state;
  move_t            r_best_move;
  eval_t            r_best_eval;
  logic             r_have_best;
  logic [CNT_W-1:0] r_num_legal;

  logic             w_counting;
  logic             w_legal;
  logic             w_take;
  logic             w_cnt_err;
  logic [CNT_W-1:0] w_out_next;
  move_t            w_best_move_nxt;
  eval_t            w_best_eval_nxt;
  logic             w_have_best_nxt;
  logic [CNT_W-1:0] w_num_legal_nxt;

  assign w_counting = !abort_in && !start_in &&
                      (r_state == SEL_COLLECT || r_state == SEL_DRAIN);

  inflight_counter #(.W(CNT_W)) u_inflight (
    .i_clk        (clk_in),
    .i_rst_n      (rst_in),
    .i_clr        (start_in && !abort_in),
    .i_inc        (issue_in && w_counting),
    .i_dec        (ret_in && w_counting),
    .o_next_count (w_out_next),
    .o_err        (w_cnt_err)
  );

  // First legal result is taken unconditionally so EVAL_MIN still registers; ties keep the earlier move.
  always_comb begin
    w_legal         = w_counting && ret_in && valid_in;
    w_take          = w_legal && (!r_have_best || (eval_in > r_best_eval));
    w_best_move_nxt = w_take ? move_in : r_best_move;
    w_best_eval_nxt = w_take ? eval_in : r_best_eval;
    w_have_best_nxt = r_have_best || w_take;
    w_num_legal_nxt = r_num_legal;
    if (w_legal && (r_num_legal != '1)) w_num_legal_nxt = r_num_legal + CNT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state          <= SEL_IDLE;
      r_best_move      <= '0;
      r_best_eval      <= '0;
      r_have_best      <= 1'b0;
      r_num_legal      <= '0;
      best_move_out    <= '0;
      best_eval_out    <= '0;
      num_legal_out    <= '0;
      no_legal_out     <= 1'b0;
      result_valid_out <= 1'b0;
      busy_out         <= 1'b0;
      error_out        <= 1'b0;
    end else if (abort_in) begin
      r_state          <= SEL_IDLE;
      result_valid_out <= 1'b0;
      busy_out         <= 1'b0;
    end else if (start_in) begin
      r_state          <= SEL_COLLECT;
      r_best_move      <= '0;
      r_best_eval      <= '0;
      r_have_best      <= 1'b0;
      r_num_legal      <= '0;
      result_valid_out <= 1'b0;
      busy_out         <= 1'b1;
      error_out        <= 1'b0;
    end else begin
      result_valid_out <= 1'b0;
      r_best_move      <= w_best_move_nxt;
      r_best_eval      <= w_best_eval_nxt;
      r_have_best      <= w_have_best_nxt;
      r_num_legal      <= w_num_legal_nxt;
      if (w_cnt_err || ((issue_in || ret_in) && !w_counting) ||
          (issue_in && r_state == SEL_DRAIN))
        error_out <= 1'b1;
      unique case (r_state)
        SEL_IDLE: ;
        SEL_COLLECT: begin
          if (gen_done_in) r_state <= SEL_DRAIN;
        end
        SEL_DRAIN: begin
          if (w_out_next == '0) begin
            r_state          <= SEL_DONE;
            result_valid_out <= 1'b1;
            best_move_out    <= w_have_best_nxt ? w_best_move_nxt : '0;
            best_eval_out    <= w_have_best_nxt ? w_best_eval_nxt : '0;
            num_legal_out    <= w_num_legal_nxt;
            no_legal_out     <= !w_have_best_nxt;
          end
        end
        SEL_DONE: begin
          r_state  <= SEL_IDLE;
          busy_out <= 1'b0;
        end
        default: r_state <= SEL_IDLE;
      endcase
    end
  end

endmodule
